datapath_gen: RTL and testbench

// - Parametrised successor to the 4-bit CPU datapath: accumulator, carry flag, register file and branch-condition logic.
// - Generalised in word width and register count; adds resettable registers and a multi-cycle rotate-through-carry unit.
// - Sits between the instruction decoder (control strobes) and the external ALU and data bus.

---
 rtl/datapath_gen_if.sv | 58 +++++
 rtl/datapath_gen.sv | 162 ++++++++++++++++
 tb/tb_datapath_gen.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_gen_if.sv
// Decoder/bus side of the generalised accumulator datapath.
// Master drives control strobes and bus values; slave is the datapath.
interface datapath_gen_if #(
  parameter int WIDTH   = 4,
  parameter int RADDR_W = 4
);
  localparam int CNT_W = $clog2(WIDTH + 2);

  logic [WIDTH-1:0]   data;
  logic [WIDTH:0]     alu_result;
  logic [RADDR_W-1:0] operand;
  logic [2:0]         acc_input_sel;
  logic [1:0]         reg_input_sel;
  logic               clear_carry;
  logic               write_carry;
  logic               clear_accumulator;
  logic               write_accumulator;
  logic               write_register;
  logic               write_pair;
  logic [2*WIDTH-1:0] pair_data;
  logic [3:0]         br_cond;
  logic               test;
  logic               rot_start;
  logic               rot_dir;
  logic [CNT_W-1:0]   rot_count;

  logic [WIDTH-1:0]   regval;
  logic [WIDTH-1:0]   acc;
  logic               carry_out;
  logic               take_branch;
  logic               reg_is_zero;
  logic               rot_busy;
  logic               rot_done;

  modport master (
    output data, alu_result, operand,
    output acc_input_sel, reg_input_sel,
    output clear_carry, write_carry,
    output clear_accumulator, write_accumulator,
    output write_register, write_pair, pair_data,
    output br_cond, test,
    output rot_start, rot_dir, rot_count,
    input  regval, acc, carry_out, take_branch,
    input  reg_is_zero, rot_busy, rot_done
  );

  modport slave (
    input  data, alu_result, operand,
    input  acc_input_sel, reg_input_sel,
    input  clear_carry, write_carry,
    input  clear_accumulator, write_accumulator,
    input  write_register, write_pair, pair_data,
    input  br_cond, test,
    input  rot_start, rot_dir, rot_count,
    output regval, acc, carry_out, take_branch,
    output reg_is_zero, rot_busy, rot_done
  );
endinterface

// File: rtl/datapath_gen.sv
// Accumulator/carry/register-file datapath with rotate-through-carry unit.
// Define DATAPATH_REG_PAIR_EN to enable register-pair writes.
module datapath_gen #(
  parameter int WIDTH    = 4,
  parameter int NUM_REGS = 16,
  parameter int RADDR_W  = 4
) (
  input logic          clock,
  input logic          reset,
  input logic          halt,
  datapath_gen_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nx;
  logic               dir;
  logic               dir_nx;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   acc_nx;
  logic               carry_q;
  logic               carry_nx;

  logic [WIDTH-1:0]   regs [NUM_REGS];
  logic [WIDTH-1:0]   rd;
  logic               in_range;
  logic [WIDTH-1:0]   acc_in;
  logic               acc_sel_ok;
  logic [WIDTH-1:0]   reg_in;
  logic               reg_sel_ok;
  logic               reg_we;

  assign in_range = int'(bus.operand) < NUM_REGS;
  assign rd       = in_range ? regs[bus.operand] : '0;

  always_comb begin
    acc_in     = '0;
    acc_sel_ok = 1'b1;
    unique case (1'b1)
      bus.acc_input_sel == 3'd0: acc_in = rd;
      bus.acc_input_sel == 3'd1: acc_in = bus.data;
      bus.acc_input_sel == 3'd2: acc_in = bus.alu_result[WIDTH-1:0];
      bus.acc_input_sel == 3'd3: acc_in = WIDTH'(bus.operand);
      bus.acc_input_sel == 3'd4: acc_in = WIDTH'(carry_q);
      default:                   acc_sel_ok = 1'b0;
    endcase
  end

  always_comb begin
    reg_in     = '0;
    reg_sel_ok = 1'b1;
    unique case (1'b1)
      bus.reg_input_sel == 2'd0: reg_in = acc_q;
      bus.reg_input_sel == 2'd1: reg_in = bus.alu_result[WIDTH-1:0];
      bus.reg_input_sel == 2'd2: reg_in = bus.data;
      default:                   reg_sel_ok = 1'b0;
    endcase
  end

  assign reg_we = bus.write_register && reg_sel_ok && in_range;

`ifdef DATAPATH_REG_PAIR_EN
  logic [RADDR_W-1:0] pair_hi;
  logic [RADDR_W-1:0] pair_lo;
  logic               pair_we;

  assign pair_hi = {bus.operand[RADDR_W-1:1], 1'b0};
  assign pair_lo = {bus.operand[RADDR_W-1:1], 1'b1};
  // NUM_REGS is even, so an in-range even index has an in-range partner
  assign pair_we = bus.write_pair && (int'(pair_hi) < NUM_REGS);
`else
  logic unused_pair;
  assign unused_pair = ^{bus.write_pair, bus.pair_data};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (!halt) begin
`ifdef DATAPATH_REG_PAIR_EN
      if (pair_we) begin
        regs[pair_hi] <= bus.pair_data[2*WIDTH-1:WIDTH];
        regs[pair_lo] <= bus.pair_data[WIDTH-1:0];
      end else if (reg_we) begin
        regs[bus.operand] <= reg_in;
      end
`else
      if (reg_we) regs[bus.operand] <= reg_in;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      dir     <= 1'b0;
      acc_q   <= '0;
      carry_q <= 1'b1;
    end else if (!halt) begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      dir     <= dir_nx;
      acc_q   <= acc_nx;
      carry_q <= carry_nx;
    end
  end

  // Outside IDLE the rotator owns acc and carry.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dir_nx   = dir;
    acc_nx   = acc_q;
    carry_nx = carry_q;
    unique case (state)
      IDLE: begin
        if (bus.clear_carry) carry_nx = 1'b0;
        else if (bus.write_carry) carry_nx = bus.alu_result[WIDTH];
        if (bus.clear_accumulator) acc_nx = '0;
        else if (bus.write_accumulator && acc_sel_ok) acc_nx = acc_in;
        if (bus.rot_start) begin
          dir_nx   = bus.rot_dir;
          cnt_nx   = bus.rot_count;
          state_nx = (bus.rot_count == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (dir) begin
          carry_nx = acc_q[0];
          acc_nx   = {carry_q, acc_q[WIDTH-1:1]};
        end else begin
          carry_nx = acc_q[WIDTH-1];
          acc_nx   = {acc_q[WIDTH-2:0], carry_q};
        end
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.regval      = rd;
  assign bus.acc         = acc_q;
  assign bus.carry_out   = carry_q;
  assign bus.reg_is_zero = (rd == '0);
  assign bus.rot_busy    = (state == SHIFT);
  assign bus.rot_done    = (state == DONE);
  assign bus.take_branch = bus.br_cond[3] ^
                           ((bus.br_cond[0] & bus.test) |
                            (bus.br_cond[1] & carry_q) |
                            (bus.br_cond[2] & (acc_q == '0)));
endmodule

// File: tb/tb_datapath_gen.sv
// Directed bench for datapath_gen (WIDTH=4, NUM_REGS=16).
// Pair-write expectations follow DATAPATH_REG_PAIR_EN.
module tb_datapath_gen;
  logic clock;
  logic reset;
  logic halt;
  int   checks;
  int   errors;

  datapath_gen_if #(.WIDTH(4), .RADDR_W(4)) bus ();

  datapath_gen #(.WIDTH(4), .NUM_REGS(16), .RADDR_W(4)) dut (
    .clock(clock),
    .reset(reset),
    .halt (halt),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clr();
    bus.data = '0;
    bus.alu_result = '0;
    bus.operand = '0;
    bus.acc_input_sel = 3'd7;
    bus.reg_input_sel = 2'd3;
    bus.clear_carry = 0;
    bus.write_carry = 0;
    bus.clear_accumulator = 0;
    bus.write_accumulator = 0;
    bus.write_register = 0;
    bus.write_pair = 0;
    bus.pair_data = '0;
    bus.br_cond = '0;
    bus.test = 0;
    bus.rot_start = 0;
    bus.rot_dir = 0;
    bus.rot_count = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; halt = 1;
    bus.write_accumulator = 1; bus.acc_input_sel = 3'd1; bus.data = 4'hF;
    bus.write_register = 1; bus.reg_input_sel = 2'd2; bus.rot_start = 1;
    tick(); tick();
    reset = 0;
    tick();
    clr(); #1;
    checks++; if (bus.acc !== 4'h0) begin errors++; $display("FAIL reset_acc got %h want 0", bus.acc); end
    checks++; if (bus.carry_out !== 1'b1) begin errors++; $display("FAIL reset_carry got %b want 1", bus.carry_out); end
    checks++; if (bus.rot_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.rot_busy); end
    checks++; if (bus.rot_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.rot_done); end
    for (int i = 0; i < 16; i++) begin
      bus.operand = 4'(i); #1;
      checks++; if (bus.regval !== 4'h0) begin errors++; $display("FAIL reset_reg%0d got %h want 0", i, bus.regval); end
      checks++; if (bus.reg_is_zero !== 1'b1) begin errors++; $display("FAIL reset_zero%0d got %b want 1", i, bus.reg_is_zero); end
    end
    bus.write_accumulator = 1; bus.acc_input_sel = 3'd1; bus.data = 4'h9; bus.clear_carry = 1;
    tick();
    checks++; if (bus.acc !== 4'h0) begin errors++; $display("FAIL halt_acc got %h want 0", bus.acc); end
    checks++; if (bus.carry_out !== 1'b1) begin errors++; $display("FAIL halt_carry got %b want 1", bus.carry_out); end
    clr();
    halt = 0;
  endtask

  task automatic test_acc_carry();
    clr(); bus.alu_result = 5'b1_0110; bus.acc_input_sel = 3'd2;
    bus.write_accumulator = 1; bus.write_carry = 1;
    tick();
    checks++; if (bus.acc !== 4'h6) begin errors++; $display("FAIL alu_acc got %h want 6", bus.acc); end
    checks++; if (bus.carry_out !== 1'b1) begin errors++; $display("FAIL alu_carry got %b want 1", bus.carry_out); end
    bus.clear_carry = 1;
    tick();
    checks++; if (bus.carry_out !== 1'b0) begin errors++; $display("FAIL clr_carry_prio got %b want 0", bus.carry_out); end
    clr(); bus.clear_accumulator = 1; bus.write_accumulator = 1; bus.acc_input_sel = 3'd1; bus.data = 4'hF;
    tick();
    checks++; if (bus.acc !== 4'h0) begin errors++; $display("FAIL clr_acc_prio got %h want 0", bus.acc); end
    clr(); bus.acc_input_sel = 3'd3; bus.operand = 4'd9; bus.write_accumulator = 1;
    tick();
    checks++; if (bus.acc !== 4'h9) begin errors++; $display("FAIL imm_acc got %h want 9", bus.acc); end
    bus.acc_input_sel = 3'd5; bus.data = 4'h3;
    tick();
    checks++; if (bus.acc !== 4'h9) begin errors++; $display("FAIL sel5_nowrite got %h want 9", bus.acc); end
    clr(); bus.write_carry = 1; bus.alu_result = 5'b1_0000;
    tick();
    clr(); bus.acc_input_sel = 3'd4; bus.write_accumulator = 1;
    tick();
    checks++; if (bus.acc !== 4'h1) begin errors++; $display("FAIL carry_to_acc got %h want 1", bus.acc); end
    clr();
  endtask

  task automatic test_regs();
    clr(); bus.data = 4'h7; bus.reg_input_sel = 2'd2; bus.operand = 4'd5; bus.write_register = 1;
    tick();
    bus.write_register = 0; #1;
    checks++; if (bus.regval !== 4'h7) begin errors++; $display("FAIL reg5_data got %h want 7", bus.regval); end
    checks++; if (bus.reg_is_zero !== 1'b0) begin errors++; $display("FAIL reg5_zero got %b want 0", bus.reg_is_zero); end
    clr(); bus.reg_input_sel = 2'd0; bus.operand = 4'd6; bus.write_register = 1;
    bus.acc_input_sel = 3'd1; bus.data = 4'hB; bus.write_accumulator = 1;
    tick();
    clr(); bus.operand = 4'd6; #1;
    checks++; if (bus.regval !== 4'h1) begin errors++; $display("FAIL reg6_preacc got %h want 1", bus.regval); end
    checks++; if (bus.acc !== 4'hB) begin errors++; $display("FAIL acc_same_cycle got %h want b", bus.acc); end
    clr(); bus.reg_input_sel = 2'd1; bus.alu_result = 5'b0_1101; bus.operand = 4'd7; bus.write_register = 1;
    tick();
    bus.reg_input_sel = 2'd3; bus.data = 4'h2;
    tick();
    bus.write_register = 0; #1;
    checks++; if (bus.regval !== 4'hD) begin errors++; $display("FAIL reg7_alu got %h want d", bus.regval); end
    clr(); bus.acc_input_sel = 3'd0; bus.operand = 4'd5; bus.write_accumulator = 1;
    tick();
    checks++; if (bus.acc !== 4'h7) begin errors++; $display("FAIL reg_to_acc got %h want 7", bus.acc); end
    clr();
  endtask

  task automatic test_rotate();
    clr(); bus.acc_input_sel = 3'd1; bus.data = 4'b1001; bus.write_accumulator = 1; bus.clear_carry = 1;
    tick();
    clr(); bus.rot_start = 1; bus.rot_dir = 0; bus.rot_count = 3'd3;
    tick();
    bus.rot_start = 0;
    for (int k = 1; k <= 3; k++) begin
      checks++; if (bus.rot_busy !== 1'b1) begin errors++; $display("FAIL rot_busy_c%0d got %b want 1", k, bus.rot_busy); end
      checks++; if (bus.rot_done !== 1'b0) begin errors++; $display("FAIL rot_nodone_c%0d got %b want 0", k, bus.rot_done); end
      if (k == 2) begin
        bus.clear_accumulator = 1; bus.write_carry = 1; bus.alu_result = 5'b1_0000;
        bus.rot_start = 1; bus.rot_count = 3'd0;
      end
      tick();
    end
    clr(); #1;
    checks++; if (bus.rot_done !== 1'b1) begin errors++; $display("FAIL rot_done_c4 got %b want 1", bus.rot_done); end
    checks++; if (bus.rot_busy !== 1'b0) begin errors++; $display("FAIL rot_busy_c4 got %b want 0", bus.rot_busy); end
    checks++; if (bus.acc !== 4'b1010) begin errors++; $display("FAIL rotl3_acc got %b want 1010", bus.acc); end
    checks++; if (bus.carry_out !== 1'b0) begin errors++; $display("FAIL rotl3_carry got %b want 0", bus.carry_out); end
    tick();
    checks++; if (bus.rot_done !== 1'b0) begin errors++; $display("FAIL rot_done_pulse got %b want 0", bus.rot_done); end
    bus.rot_start = 1; bus.rot_count = 3'd0;
    tick();
    bus.rot_start = 0; #1;
    checks++; if (bus.rot_done !== 1'b1) begin errors++; $display("FAIL rot0_done got %b want 1", bus.rot_done); end
    checks++; if (bus.rot_busy !== 1'b0) begin errors++; $display("FAIL rot0_busy got %b want 0", bus.rot_busy); end
    checks++; if (bus.acc !== 4'b1010) begin errors++; $display("FAIL rot0_acc got %b want 1010", bus.acc); end
    tick();
    bus.rot_start = 1; bus.rot_dir = 1; bus.rot_count = 3'd2;
    tick();
    bus.rot_start = 0;
    halt = 1;
    tick(); tick();
    checks++; if (bus.rot_busy !== 1'b1) begin errors++; $display("FAIL halt_busy got %b want 1", bus.rot_busy); end
    checks++; if (bus.acc !== 4'b1010) begin errors++; $display("FAIL halt_rot_acc got %b want 1010", bus.acc); end
    halt = 0;
    tick();
    checks++; if (bus.acc !== 4'b0101) begin errors++; $display("FAIL rotr1_acc got %b want 0101", bus.acc); end
    tick();
    checks++; if (bus.rot_done !== 1'b1) begin errors++; $display("FAIL rotr_done got %b want 1", bus.rot_done); end
    checks++; if (bus.acc !== 4'b0010) begin errors++; $display("FAIL rotr2_acc got %b want 0010", bus.acc); end
    checks++; if (bus.carry_out !== 1'b1) begin errors++; $display("FAIL rotr2_carry got %b want 1", bus.carry_out); end
    tick();
    clr();
  endtask

  task automatic test_reset_abort();
    clr(); bus.acc_input_sel = 3'd1; bus.data = 4'b0001; bus.write_accumulator = 1;
    bus.write_carry = 1; bus.alu_result = 5'b1_0000;
    tick();
    clr(); bus.rot_start = 1; bus.rot_dir = 1; bus.rot_count = 3'd1;
    tick();
    bus.rot_start = 0;
    checks++; if (bus.rot_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_pre got %b want 1", bus.rot_busy); end
    reset = 1;
    tick();
    reset = 0;
    checks++; if (bus.acc !== 4'h0) begin errors++; $display("FAIL abort_acc got %h want 0", bus.acc); end
    checks++; if (bus.carry_out !== 1'b1) begin errors++; $display("FAIL abort_carry got %b want 1", bus.carry_out); end
    checks++; if (bus.rot_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus.rot_busy); end
    checks++; if (bus.rot_done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", bus.rot_done); end
    tick();
    checks++; if (bus.rot_done !== 1'b0) begin errors++; $display("FAIL abort_nodone got %b want 0", bus.rot_done); end
    bus.operand = 4'd5; #1;
    checks++; if (bus.regval !== 4'h0) begin errors++; $display("FAIL abort_reg5 got %h want 0", bus.regval); end
    clr();
  endtask

  task automatic test_branch();
    clr(); bus.br_cond = 4'b1100; #1;
    checks++; if (bus.take_branch !== 1'b0) begin errors++; $display("FAIL br_inv_acc0 got %b want 0", bus.take_branch); end
    bus.acc_input_sel = 3'd3; bus.operand = 4'd3; bus.write_accumulator = 1;
    tick();
    clr(); bus.br_cond = 4'b1100; #1;
    checks++; if (bus.take_branch !== 1'b1) begin errors++; $display("FAIL br_inv_acc3 got %b want 1", bus.take_branch); end
    bus.br_cond = 4'b0001; bus.test = 1; #1;
    checks++; if (bus.take_branch !== 1'b1) begin errors++; $display("FAIL br_test1 got %b want 1", bus.take_branch); end
    bus.test = 0; #1;
    checks++; if (bus.take_branch !== 1'b0) begin errors++; $display("FAIL br_test0 got %b want 0", bus.take_branch); end
    bus.br_cond = 4'b0010; #1;
    checks++; if (bus.take_branch !== 1'b1) begin errors++; $display("FAIL br_carry got %b want 1", bus.take_branch); end
    bus.br_cond = 4'b1010; #1;
    checks++; if (bus.take_branch !== 1'b0) begin errors++; $display("FAIL br_ncarry got %b want 0", bus.take_branch); end
    clr();
  endtask

  task automatic test_pair();
    logic [3:0] e2;
    logic [3:0] e3;
`ifdef DATAPATH_REG_PAIR_EN
    e2 = 4'hA; e3 = 4'h5;
`else
    e2 = 4'h0; e3 = 4'hE;
`endif
    clr(); bus.operand = 4'd3; bus.pair_data = 8'hA5; bus.write_pair = 1;
    bus.write_register = 1; bus.reg_input_sel = 2'd2; bus.data = 4'hE;
    tick();
    clr(); bus.operand = 4'd2; #1;
    checks++; if (bus.regval !== e2) begin errors++; $display("FAIL pair_reg2 got %h want %h", bus.regval, e2); end
    bus.operand = 4'd3; #1;
    checks++; if (bus.regval !== e3) begin errors++; $display("FAIL pair_reg3 got %h want %h", bus.regval, e3); end
    clr();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1;
    halt = 1;
    clr();
    test_reset();
    test_acc_carry();
    test_regs();
    test_rotate();
    test_reset_abort();
    test_branch();
    test_pair();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
